// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decoded ID fields, hazard controls, forwarding sources and the registered
// EX-side outputs that feed the ALU and later stages.
interface id_ex_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RA_W   = 5
);
  logic              stall;
  logic              flush;
  logic              id_valid;
  logic [DATA_W-1:0] id_pc;
  logic [DATA_W-1:0] id_readdata1;
  logic [DATA_W-1:0] id_readdata2;
  logic [DATA_W-1:0] id_imm;
  logic [RA_W-1:0]   id_rs1;
  logic [RA_W-1:0]   id_rs2;
  logic [RA_W-1:0]   id_rd;
  logic [1:0]        id_aluop;
  logic [2:0]        id_funct3;
  logic              id_funct7b5;
  logic              id_alusrc;
  logic              id_regwrite;
  logic              id_memread;
  logic              id_memwrite;
  logic              id_memtoreg;
  logic              id_branch;
  logic [1:0]        forward_a;
  logic [1:0]        forward_b;
  logic [DATA_W-1:0] ex_mem_aluresult;
  logic [DATA_W-1:0] mem_wb_writedata;

  logic              ex_valid;
  logic [DATA_W-1:0] ex_pc;
  logic [DATA_W-1:0] readdata1;
  logic [DATA_W-1:0] ALUSrcResult;
  logic [3:0]        ALUControlOp;
  logic [DATA_W-1:0] ex_storedata;
  logic [DATA_W-1:0] ex_imm;
  logic [RA_W-1:0]   ex_rs1;
  logic [RA_W-1:0]   ex_rs2;
  logic [RA_W-1:0]   ex_rd;
  logic              ex_regwrite;
  logic              ex_memread;
  logic              ex_memwrite;
  logic              ex_memtoreg;
  logic              ex_branch;

  modport master (
    output stall, flush, id_valid, id_pc, id_readdata1, id_readdata2, id_imm,
           id_rs1, id_rs2, id_rd, id_aluop, id_funct3, id_funct7b5, id_alusrc,
           id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch,
           forward_a, forward_b, ex_mem_aluresult, mem_wb_writedata,
    input  ex_valid, ex_pc, readdata1, ALUSrcResult, ALUControlOp, ex_storedata,
           ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch
  );

  modport slave (
    input  stall, flush, id_valid, id_pc, id_readdata1, id_readdata2, id_imm,
           id_rs1, id_rs2, id_rd, id_aluop, id_funct3, id_funct7b5, id_alusrc,
           id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch,
           forward_a, forward_b, ex_mem_aluresult, mem_wb_writedata,
    output ex_valid, ex_pc, readdata1, ALUSrcResult, ALUControlOp, ex_storedata,
           ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-control decode ahead of the register and combinational
// operand forwarding after it. Supports hold (stall) and bubble insertion (flush).
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RA_W   = 5
) (
  input logic         clk,
  input logic         rst_n,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [RA_W-1:0]   rs1;
    logic [RA_W-1:0]   rs2;
    logic [RA_W-1:0]   rd;
    logic [3:0]        alu_ctrl;
    logic              alusrc;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
    logic              branch;
  } stage_t;

  stage_t            stage_d, stage_q;
  logic [3:0]        alu_ctrl_id;
  logic [DATA_W-1:0] op_a, op_b_fwd;

  // 10 selects EX/MEM, 01 selects MEM/WB; 00 and 11 keep the stage value.
  function automatic logic [DATA_W-1:0] fwd_sel(input logic [1:0]        sel,
                                                input logic [DATA_W-1:0] stage_val,
                                                input logic [DATA_W-1:0] ex_mem_val,
                                                input logic [DATA_W-1:0] mem_wb_val);
    case (sel)
      2'b10:   return ex_mem_val;
      2'b01:   return mem_wb_val;
      default: return stage_val;
    endcase
  endfunction

  always_comb begin
    alu_ctrl_id = 4'b1111;
    case (bus.id_aluop)
      2'b00: alu_ctrl_id = 4'b0010;
      2'b01: alu_ctrl_id = 4'b0110;
      2'b10: begin
        case (bus.id_funct3)
          // funct7b5 only means sub for register-register forms; addi reuses that bit.
          3'b000:  alu_ctrl_id = (bus.id_funct7b5 && !bus.id_alusrc) ? 4'b0110 : 4'b0010;
          3'b111:  alu_ctrl_id = 4'b0000;
          3'b110:  alu_ctrl_id = 4'b0001;
          3'b010:  alu_ctrl_id = 4'b0111;
          default: alu_ctrl_id = 4'b1111;
        endcase
      end
      default: alu_ctrl_id = 4'b1111;
    endcase
  end

  always_comb begin
    stage_d = stage_q;
    if (bus.flush) begin
      stage_d = '0;
    end else if (!bus.stall) begin
      stage_d.valid    = bus.id_valid;
      stage_d.pc       = bus.id_pc;
      stage_d.rd1      = bus.id_readdata1;
      stage_d.rd2      = bus.id_readdata2;
      stage_d.imm      = bus.id_imm;
      stage_d.rs1      = bus.id_rs1;
      stage_d.rs2      = bus.id_rs2;
      stage_d.rd       = bus.id_rd;
      stage_d.alu_ctrl = alu_ctrl_id;
      stage_d.alusrc   = bus.id_alusrc;
      stage_d.regwrite = bus.id_valid & bus.id_regwrite;
      stage_d.memread  = bus.id_valid & bus.id_memread;
      stage_d.memwrite = bus.id_valid & bus.id_memwrite;
      stage_d.memtoreg = bus.id_valid & bus.id_memtoreg;
      stage_d.branch   = bus.id_valid & bus.id_branch;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  always_comb begin
    op_a     = fwd_sel(bus.forward_a, stage_q.rd1, bus.ex_mem_aluresult, bus.mem_wb_writedata);
    op_b_fwd = fwd_sel(bus.forward_b, stage_q.rd2, bus.ex_mem_aluresult, bus.mem_wb_writedata);
  end

  always_comb begin
    bus.ex_valid     = stage_q.valid;
    bus.ex_pc        = stage_q.pc;
    bus.readdata1    = op_a;
    bus.ALUSrcResult = stage_q.alusrc ? stage_q.imm : op_b_fwd;
    bus.ALUControlOp = stage_q.alu_ctrl;
    bus.ex_storedata = op_b_fwd;
    bus.ex_imm       = stage_q.imm;
    bus.ex_rs1       = stage_q.rs1;
    bus.ex_rs2       = stage_q.rs2;
    bus.ex_rd        = stage_q.rd;
    bus.ex_regwrite  = stage_q.regwrite;
    bus.ex_memread   = stage_q.memread;
    bus.ex_memwrite  = stage_q.memwrite;
    bus.ex_memtoreg  = stage_q.memtoreg;
    bus.ex_branch    = stage_q.branch;
  end

endmodule
